duft_responder: RTL and testbench

DUFT_RESPONDER -- requirements
Module: duft_responder

---
 rtl/duft_responder_pkg.sv | 25 ++
 rtl/duft_scan_chain.sv | 46 ++++
 rtl/duft_responder.sv | 185 ++++++++++++++++++
 tb/tb_duft_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duft_responder_pkg.sv
// Shared FSM state types and default sizing for the DUT/DFT responder.
package duft_responder_pkg;

  typedef enum logic [1:0] {
    U_IDLE   = 2'd0,
    U_BUSY   = 2'd1,
    U_COMMIT = 2'd2
  } dut_state_t;

  typedef enum logic [1:0] {
    D_IDLE   = 2'd0,
    D_SHIFT  = 2'd1,
    D_STROBE = 2'd2,
    D_COMMIT = 2'd3
  } dft_state_t;

  localparam int DEF_CHAIN_LEN = 32;
  localparam int DEF_DUMP_NBR  = 1;
  localparam int DEF_OP_LAT    = 2;

  localparam int OP_CNT_W    = 4;
  localparam int SHIFT_CNT_W = 6;
  localparam int DUMP_CNT_W  = 27;

endpackage

// File: rtl/duft_scan_chain.sv
// Rotating scan chain with a word packer; each shift moves the chain MSB
// back into the chain LSB and into the packed word LSB.
module duft_scan_chain
  import duft_responder_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 clear_word,
  input  logic [CHAIN_LEN-1:0] load_value,
  output logic [CHAIN_LEN-1:0] word
);

  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] chain_rot;
  logic [CHAIN_LEN-1:0] word_shl;

  generate
    if (CHAIN_LEN == 1) begin : g_one
      assign chain_rot = chain;
      assign word_shl  = chain;
    end else begin : g_many
      assign chain_rot = {chain[CHAIN_LEN-2:0], chain[CHAIN_LEN-1]};
      assign word_shl  = {word[CHAIN_LEN-2:0], chain[CHAIN_LEN-1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      word  <= '0;
    end else if (load) begin
      chain <= load_value;
      word  <= '0;
    end else if (shift) begin
      chain <= chain_rot;
      word  <= word_shl;
    end else if (clear_word) begin
      word <= '0;
    end
  end

endmodule

// File: rtl/duft_responder.sv
// Responder arbitrating accumulate operations (DUT) against scan dumps of the
// accumulator (DFT); only one side runs at a time, DUT wins ties.
//   state    | meaning
//   U_IDLE   | no DUT op in flight
//   U_BUSY   | counting down compute latency, frozen while ex_sen is high
//   U_COMMIT | result on data_out, waiting for dut_commit_ack
//   D_IDLE   | no dump in flight
//   D_SHIFT  | rotating the chain one bit per cycle into the word
//   D_STROBE | presenting one dump word
//   D_COMMIT | dump finished, waiting for dft_commit_ack
module duft_responder
  import duft_responder_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int DUMP_NBR  = DEF_DUMP_NBR,
  parameter int OP_LAT    = DEF_OP_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        dut_val_op,
  output logic        dut_op_ack,
  output logic        dut_op_commit,
  input  logic        dut_commit_ack,
  input  logic        dft_val_op,
  output logic        dft_op_ack,
  output logic [31:0] dft_out,
  output logic        dft_out_strobe,
  output logic        dft_op_commit,
  input  logic        dft_commit_ack,
  input  logic        ex_sen
);

  localparam logic [OP_CNT_W-1:0]    OP_LAT_C    = OP_CNT_W'(OP_LAT);
  localparam logic [SHIFT_CNT_W-1:0] CHAIN_LEN_C = SHIFT_CNT_W'(CHAIN_LEN);
  localparam logic [DUMP_CNT_W-1:0]  DUMP_NBR_C  = DUMP_CNT_W'(DUMP_NBR);

  dut_state_t u_state, u_next;
  dft_state_t d_state, d_next;

  logic                   armed;
  logic [OP_CNT_W-1:0]    op_cnt;
  logic [31:0]            operand;
  logic [31:0]            acc;
  logic [SHIFT_CNT_W-1:0] shift_cnt;
  logic [DUMP_CNT_W-1:0]  dump_cnt;
  logic [DUMP_CNT_W-1:0]  dump_cnt_inc;
  logic [31:0]            dft_hold;
  logic [CHAIN_LEN-1:0]   word;
  logic [31:0]            word_ext;

  logic both_idle, dut_grant, dft_grant, op_done, last_shift, last_dump;
  logic chain_load, chain_shift, word_clear;

  // armed stays low through the first cycle after reset so no request is acked there
  assign both_idle    = armed && (u_state == U_IDLE) && (d_state == D_IDLE);
  assign dut_grant    = both_idle && dut_val_op;
  assign dft_grant    = both_idle && dft_val_op && !dut_grant;
  assign op_done      = (u_state == U_BUSY) && !ex_sen && (op_cnt == OP_CNT_W'(1));
  assign last_shift   = (shift_cnt == SHIFT_CNT_W'(1));
  assign dump_cnt_inc = dump_cnt + DUMP_CNT_W'(1);
  assign last_dump    = (dump_cnt_inc == DUMP_NBR_C);
  assign word_ext     = 32'(word);

  always_comb begin
    u_next        = u_state;
    dut_op_ack    = 1'b0;
    dut_op_commit = 1'b0;
    case (u_state)
      U_IDLE: begin
        if (dut_grant) begin
          dut_op_ack = 1'b1;
          u_next     = U_BUSY;
        end
      end
      U_BUSY: begin
        if (op_done) u_next = U_COMMIT;
      end
      U_COMMIT: begin
        dut_op_commit = 1'b1;
        if (dut_commit_ack) u_next = U_IDLE;
      end
      default: u_next = U_IDLE;
    endcase
  end

  always_comb begin
    d_next         = d_state;
    dft_op_ack     = 1'b0;
    dft_out_strobe = 1'b0;
    dft_op_commit  = 1'b0;
    chain_load     = 1'b0;
    chain_shift    = 1'b0;
    word_clear     = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (dft_grant) begin
          dft_op_ack = 1'b1;
          chain_load = 1'b1;
          d_next     = D_SHIFT;
        end
      end
      D_SHIFT: begin
        chain_shift = 1'b1;
        if (last_shift) d_next = D_STROBE;
      end
      D_STROBE: begin
        dft_out_strobe = 1'b1;
        if (last_dump) begin
          d_next = D_COMMIT;
        end else begin
          word_clear = 1'b1;
          d_next     = D_SHIFT;
        end
      end
      D_COMMIT: begin
        dft_op_commit = 1'b1;
        if (dft_commit_ack) d_next = D_IDLE;
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state <= U_IDLE;
      d_state <= D_IDLE;
      armed   <= 1'b0;
    end else begin
      u_state <= u_next;
      d_state <= d_next;
      armed   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_cnt    <= '0;
      operand   <= '0;
      acc       <= '0;
      shift_cnt <= '0;
      dump_cnt  <= '0;
      dft_hold  <= '0;
    end else begin
      if (dut_grant) begin
        operand <= data_in;
        op_cnt  <= OP_LAT_C;
      end else if ((u_state == U_BUSY) && !ex_sen) begin
        op_cnt <= op_cnt - OP_CNT_W'(1);
      end
      if (op_done) acc <= acc + operand;

      if (dft_grant) begin
        shift_cnt <= CHAIN_LEN_C;
        dump_cnt  <= '0;
      end else if (chain_shift) begin
        shift_cnt <= shift_cnt - SHIFT_CNT_W'(1);
      end else if (word_clear) begin
        shift_cnt <= CHAIN_LEN_C;
      end
      if (dft_out_strobe) begin
        dump_cnt <= dump_cnt_inc;
        dft_hold <= word_ext;
      end
    end
  end

  duft_scan_chain #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_chain (
    .clk       (clk),
    .reset     (reset),
    .load      (chain_load),
    .shift     (chain_shift),
    .clear_word(word_clear),
    .load_value(acc[CHAIN_LEN-1:0]),
    .word      (word)
  );

  assign data_out = acc;
  // The live word is shown only during the strobe; otherwise the last strobed word is held.
  assign dft_out  = (d_state == D_STROBE) ? word_ext : dft_hold;

endmodule

// File: tb/tb_duft_responder.sv
// Bench for duft_responder: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a timestamp-based model.
module tb_duft_responder;

  localparam int CL = 32;
  localparam int DN = 3;
  localparam int OL = 2;
  localparam int PERIOD = CL + 1;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - CL);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] data_in = '0, data_out;
  logic        dut_val_op = 1'b0, dut_op_ack, dut_op_commit, dut_commit_ack = 1'b0;
  logic        dft_val_op = 1'b0, dft_op_ack, dft_out_strobe, dft_op_commit, dft_commit_ack = 1'b0;
  logic [31:0] dft_out;
  logic        ex_sen = 1'b0;

  logic [31:0] b_data_in = '0, b_data_out, b_dft_out;
  logic        b_dut_val_op = 1'b0, b_dut_op_ack, b_dut_op_commit, b_dut_commit_ack = 1'b0;
  logic        b_dft_val_op = 1'b0, b_dft_op_ack, b_dft_out_strobe, b_dft_op_commit, b_dft_commit_ack = 1'b0;
  logic        b_ex_sen = 1'b0;

  duft_responder #(.CHAIN_LEN(CL), .DUMP_NBR(DN), .OP_LAT(OL)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out),
    .dut_val_op(dut_val_op), .dut_op_ack(dut_op_ack), .dut_op_commit(dut_op_commit),
    .dut_commit_ack(dut_commit_ack), .dft_val_op(dft_val_op), .dft_op_ack(dft_op_ack),
    .dft_out(dft_out), .dft_out_strobe(dft_out_strobe), .dft_op_commit(dft_op_commit),
    .dft_commit_ack(dft_commit_ack), .ex_sen(ex_sen)
  );

  duft_responder #(.CHAIN_LEN(8), .DUMP_NBR(1), .OP_LAT(2)) dut8 (
    .clk(clk), .reset(reset), .data_in(b_data_in), .data_out(b_data_out),
    .dut_val_op(b_dut_val_op), .dut_op_ack(b_dut_op_ack), .dut_op_commit(b_dut_op_commit),
    .dut_commit_ack(b_dut_commit_ack), .dft_val_op(b_dft_val_op), .dft_op_ack(b_dft_op_ack),
    .dft_out(b_dft_out), .dft_out_strobe(b_dft_out_strobe), .dft_op_commit(b_dft_op_commit),
    .dft_commit_ack(b_dft_commit_ack), .ex_sen(b_ex_sen)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int now_c = 0;
  bit chk = 1'b0;

  // requested input values, applied at the next negedge
  logic        r_reset = 1'b1, r_dut_req = 1'b0, r_dft_req = 1'b0;
  logic        r_cack_u = 1'b0, r_cack_d = 1'b0, r_ex_sen = 1'b0;
  logic [31:0] r_data = '0, rb_data = '0;
  logic        rb_dut_req = 1'b0, rb_dft_req = 1'b0, rb_cack_u = 1'b0, rb_cack_d = 1'b0;

  // model: in-flight work tracked by cycle stamps
  logic [31:0] m_acc = '0, m_dft_last = '0, m_operand = '0;
  bit          u_act = 1'b0, d_act = 1'b0, m_fresh = 1'b1;
  int          u_commit_at = 0, d_grant = 0;

  logic        e_dut_ack, e_dut_commit, e_dft_ack, e_dft_strobe, e_dft_commit;
  logic [31:0] e_data_out, e_dft_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, now_c);
    end
  endtask

  task automatic model_expect();
    int rel;
    if (reset) begin
      u_act = 1'b0; d_act = 1'b0; m_acc = '0; m_dft_last = '0; m_fresh = 1'b1;
      e_dut_ack = 1'b0; e_dut_commit = 1'b0; e_dft_ack = 1'b0;
      e_dft_strobe = 1'b0; e_dft_commit = 1'b0; e_data_out = '0; e_dft_out = '0;
    end else begin
      rel = cyc - d_grant;
      e_dut_commit = u_act && (cyc >= u_commit_at);
      e_dft_strobe = d_act && (rel > 0) && (rel % PERIOD == 0) && (rel <= DN * PERIOD);
      e_dft_commit = d_act && (rel > DN * PERIOD);
      e_dut_ack    = !m_fresh && !u_act && !d_act && dut_val_op;
      e_dft_ack    = !m_fresh && !u_act && !d_act && dft_val_op && !e_dut_ack;
      e_data_out   = m_acc;
      e_dft_out    = e_dft_strobe ? (m_acc & MASK) : m_dft_last;
    end
  endtask

  task automatic model_advance();
    if (reset) begin
      m_fresh = 1'b1;
    end else begin
      m_fresh = 1'b0;
      if (e_dut_ack) begin
        u_act = 1'b1; u_commit_at = cyc + OL + 1; m_operand = data_in;
      end else if (u_act) begin
        if (cyc < u_commit_at && ex_sen) u_commit_at++;
        if (e_dut_commit && dut_commit_ack) u_act = 1'b0;
        else if (cyc + 1 == u_commit_at) m_acc = m_acc + m_operand;
      end
      if (e_dft_ack) begin
        d_act = 1'b1; d_grant = cyc;
      end else if (d_act) begin
        if (e_dft_strobe) m_dft_last = m_acc & MASK;
        if (e_dft_commit && dft_commit_ack) d_act = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    reset = r_reset; data_in = r_data; dut_val_op = r_dut_req; dft_val_op = r_dft_req;
    dut_commit_ack = r_cack_u; dft_commit_ack = r_cack_d; ex_sen = r_ex_sen;
    b_data_in = rb_data; b_dut_val_op = rb_dut_req; b_dft_val_op = rb_dft_req;
    b_dut_commit_ack = rb_cack_u; b_dft_commit_ack = rb_cack_d;
    now_c = cyc;
    #1;
    model_expect();
    chk = 1'b1;
    #3;
    model_advance();
    if (e_dut_ack) r_dut_req = 1'b0;
    if (e_dft_ack) r_dft_req = 1'b0;
  endtask

  always @(negedge clk) begin
    #3;
    if (chk) begin
      check("dut_op_ack", 32'(dut_op_ack), 32'(e_dut_ack));
      check("dut_op_commit", 32'(dut_op_commit), 32'(e_dut_commit));
      check("dft_op_ack", 32'(dft_op_ack), 32'(e_dft_ack));
      check("dft_out_strobe", 32'(dft_out_strobe), 32'(e_dft_strobe));
      check("dft_op_commit", 32'(dft_op_commit), 32'(e_dft_commit));
      check("data_out", data_out, e_data_out);
      check("dft_out", dft_out, e_dft_out);
    end
  end

  function automatic logic probe(input int sel);
    case (sel)
      0: return dut_op_ack;
      1: return dut_op_commit;
      2: return dft_op_ack;
      3: return dft_out_strobe;
      4: return dft_op_commit;
      5: return b_dut_op_ack;
      6: return b_dut_op_commit;
      7: return b_dft_op_ack;
      8: return b_dft_out_strobe;
      9: return b_dft_op_commit;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (probe(sel)) begin
        at = now_c;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL wait_event_%0d: not seen within %0d cycles", sel, budget);
    end
  endtask

  task automatic release_u();
    r_cack_u = 1'b1; step(); r_cack_u = 1'b0;
  endtask

  task automatic release_d();
    r_cack_d = 1'b1; step(); r_cack_d = 1'b0;
  endtask

  int t_rel, t_ack, t_c, t_g, t_s1, t_s2, t_s3, t_ca, t_b, n_ev;

  initial begin
    // reset and first accumulate ops
    repeat (3) step();
    check("rst_data_out", data_out, 32'd0);
    check("rst_dft_out", dft_out, 32'd0);
    check("rst_commit", 32'(dut_op_commit | dft_op_commit | dft_out_strobe), 32'd0);
    r_reset = 1'b0; r_dut_req = 1'b1; r_data = 32'd5;
    step(); t_rel = now_c;
    check("no_ack_first_cycle", 32'(dut_op_ack), 32'd0);
    wait_for(0, 5, t_ack);
    check("ack_second_cycle", t_ack - t_rel, 32'd1);
    wait_for(1, 20, t_c);
    check("lat_op5", t_c - t_ack, 32'd3);
    check("data_out_5", data_out, 32'd5);
    release_u();
    r_dut_req = 1'b1; r_data = 32'd7;
    wait_for(0, 5, t_ack);
    wait_for(1, 20, t_c);
    check("lat_op7", t_c - t_ack, 32'd3);
    check("data_out_12", data_out, 32'd12);
    check("model_acc_12", m_acc, 32'd12);
    release_u();

    // four stall cycles while busy
    r_dut_req = 1'b1; r_data = 32'd1;
    wait_for(0, 5, t_ack);
    r_ex_sen = 1'b1; repeat (4) step(); r_ex_sen = 1'b0;
    wait_for(1, 20, t_c);
    check("lat_stall4", t_c - t_ack, 32'd7);
    check("data_out_13", data_out, 32'd13);
    release_u();

    // three-word dump of 0xDEADBEEF
    r_dut_req = 1'b1; r_data = 32'hDEADBEEF - 32'd13;
    wait_for(0, 5, t_ack);
    wait_for(1, 20, t_c);
    check("acc_deadbeef", data_out, 32'hDEADBEEF);
    release_u();
    r_dft_req = 1'b1;
    wait_for(2, 5, t_g);
    wait_for(3, 50, t_s1);
    check("strobe1_delay", t_s1 - t_g, 32'd33);
    check("strobe1_word", dft_out, 32'hDEADBEEF);
    wait_for(3, 50, t_s2);
    check("strobe2_gap", t_s2 - t_s1, 32'd33);
    check("strobe2_word", dft_out, 32'hDEADBEEF);
    wait_for(3, 50, t_s3);
    check("strobe3_gap", t_s3 - t_s2, 32'd33);
    check("strobe3_word", dft_out, 32'hDEADBEEF);
    wait_for(4, 5, t_c);
    check("dft_commit_delay", t_c - t_s3, 32'd1);
    check("acc_after_dump", data_out, 32'hDEADBEEF);
    check("model_dump_word", m_dft_last, 32'hDEADBEEF);
    release_d();

    // simultaneous requests: DUT first, DFT right after DUT returns idle
    r_dut_req = 1'b1; r_dft_req = 1'b1; r_data = 32'd1;
    step();
    check("tie_dut_ack", 32'(dut_op_ack), 32'd1);
    check("tie_dft_wait", 32'(dft_op_ack), 32'd0);
    wait_for(1, 20, t_c);
    r_cack_u = 1'b1; step(); t_ca = now_c; r_cack_u = 1'b0;
    wait_for(2, 5, t_g);
    check("tie_dft_ack_cycle", t_g - t_ca, 32'd1);
    wait_for(4, 150, t_c);
    check("tie_dump_word", dft_out, 32'hDEADBEF0);
    release_d();

    // 8-bit chain instance
    rb_dut_req = 1'b1; rb_data = 32'h1234_56A5;
    wait_for(5, 10, t_b); rb_dut_req = 1'b0;
    wait_for(6, 10, t_b);
    rb_cack_u = 1'b1; step(); rb_cack_u = 1'b0;
    rb_dft_req = 1'b1;
    wait_for(7, 10, t_g); rb_dft_req = 1'b0;
    wait_for(8, 20, t_s1);
    check("c8_strobe_delay", t_s1 - t_g, 32'd9);
    check("c8_dft_out", b_dft_out, 32'h0000_00A5);
    check("c8_acc_kept", b_data_out, 32'h1234_56A5);
    wait_for(9, 5, t_b);
    rb_cack_d = 1'b1; step(); rb_cack_d = 1'b0;
    step();
    check("c8_dft_out_hold", b_dft_out, 32'h0000_00A5);

    // reset in the middle of shifting
    r_dft_req = 1'b1;
    wait_for(2, 5, t_g);
    repeat (5) step();
    r_reset = 1'b1; step();
    check("abort_strobe", 32'(dft_out_strobe | dft_op_commit), 32'd0);
    check("abort_dft_out", dft_out, 32'd0);
    check("abort_data_out", data_out, 32'd0);
    step(); r_reset = 1'b0;
    n_ev = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dft_out_strobe || dft_op_commit || dut_op_commit) n_ev++;
    end
    check("abort_no_events", n_ev, 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (!r_dut_req && $urandom_range(3) == 0) r_dut_req = 1'b1;
      if (!r_dft_req && $urandom_range(15) == 0) r_dft_req = 1'b1;
      r_data   = $urandom();
      r_cack_u = ($urandom_range(2) == 0);
      r_cack_d = ($urandom_range(2) == 0);
      r_ex_sen = ($urandom_range(2) == 0);
      r_reset  = ($urandom_range(399) == 0);
      step();
    end
    r_reset = 1'b0;
    step();

    chk = 1'b0;
    #10;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
